// File: rtl/display_mux.sv
// display_mux: N-digit time-multiplexed common-anode 7-seg driver with per-frame shadow capture.
// Optional brightness PWM built when DISPLAY_MUX_PWM_EN is defined; otherwise brightness is ignored.
module display_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_COUNT    = 10000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(REFRESH_COUNT);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_COUNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};

  logic [TW-1:0]           tick_cnt;
  logic [IW-1:0]           idx;
  logic                    started;
  logic [4*NUM_DIGITS-1:0] digits_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [3:0]              bright_s;

  logic                    slot_end;
  logic                    wrap;
  logic                    load;
  logic [3:0]              cur_hex;
  logic [7:0]              seg_on;
  logic                    show;
  logic                    anode_on;
  logic [NUM_DIGITS-1:0]   sel;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [7:0]              cathode_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'b0111111;
      4'h1:    hex_to_seg = 7'b0000110;
      4'h2:    hex_to_seg = 7'b1011011;
      4'h3:    hex_to_seg = 7'b1001111;
      4'h4:    hex_to_seg = 7'b1100110;
      4'h5:    hex_to_seg = 7'b1101101;
      4'h6:    hex_to_seg = 7'b1111101;
      4'h7:    hex_to_seg = 7'b0000111;
      4'h8:    hex_to_seg = 7'b1111111;
      4'h9:    hex_to_seg = 7'b1101111;
      4'hA:    hex_to_seg = 7'b1110111;
      4'hB:    hex_to_seg = 7'b1111100;
      4'hC:    hex_to_seg = 7'b0111001;
      4'hD:    hex_to_seg = 7'b1011110;
      4'hE:    hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

  assign slot_end = (tick_cnt == TICK_LAST);
  assign wrap     = started && slot_end && (idx == IDX_LAST);
  // Shadows load once right after reset and then only at the frame wrap.
  assign load     = !started || wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      started    <= 1'b0;
      tick_cnt   <= '0;
      idx        <= '0;
      digits_s   <= '0;
      dp_s       <= '0;
      blank_s    <= '0;
      bright_s   <= '0;
      anode      <= ANODE_OFF;
      cathode    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      started    <= 1'b1;
      frame_done <= wrap;
      anode      <= anode_nxt;
      cathode    <= cathode_nxt;
      if (load) begin
        digits_s <= digits;
        dp_s     <= dp;
        blank_s  <= blank;
        bright_s <= brightness;
      end
      if (started) begin
        if (slot_end) begin
          tick_cnt <= '0;
          idx      <= wrap ? '0 : idx + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

`ifdef DISPLAY_MUX_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end
`else
  logic [3:0] unused_bright;
  assign unused_bright = bright_s;
`endif

  always_comb begin
    cur_hex  = digits_s[4*idx +: 4];
    seg_on   = {dp_s[idx], hex_to_seg(cur_hex)};
    // Nothing is driven in the capture cycle before the first frame starts.
    show     = started && !blank_s[idx];
`ifdef DISPLAY_MUX_PWM_EN
    anode_on = show && (pwm_cnt <= bright_s);
`else
    anode_on = show;
`endif
    sel         = anode_on ? (NUM_DIGITS'(1) << idx) : '0;
    anode_nxt   = (ANODE_ACTIVE_LOW != 0) ? ~sel : sel;
    cathode_nxt = show ? seg_on : 8'h00;
    if (SEG_ACTIVE_LOW != 0) cathode_nxt = ~cathode_nxt;
  end

endmodule

// File: tb/tb_display_mux.sv
// Directed self-checking bench for display_mux (4 digits, 4-cycle slots, active-low outputs).
module tb_display_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  brightness;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] seg_tab [16];

  always #5 clk = ~clk;

`ifdef DISPLAY_MUX_PWM_EN
  localparam logic [3:0] MAIN_BRIGHT = 4'd15;
`else
  localparam logic [3:0] MAIN_BRIGHT = 4'd0;
`endif

  display_mux #(
    .NUM_DIGITS(4), .REFRESH_COUNT(4), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp(dp), .blank(blank),
    .brightness(brightness), .anode(anode), .cathode(cathode), .frame_done(frame_done)
  );

`ifdef DISPLAY_MUX_PWM_EN
  logic        p_reset;
  logic [3:0]  p_brightness;
  logic [3:0]  p_anode;
  logic [7:0]  p_cathode;
  logic        p_frame_done;

  display_mux #(
    .NUM_DIGITS(4), .REFRESH_COUNT(32), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) u_pwm (
    .clk(clk), .reset(p_reset), .digits(16'h3210), .dp(4'h0), .blank(4'h0),
    .brightness(p_brightness), .anode(p_anode), .cathode(p_cathode), .frame_done(p_frame_done)
  );
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_anode"}, 32'(anode), 32'h0F);
    check_val({tag, "_cathode"}, 32'(cathode), 32'hFF);
    check_val({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // Checks one full frame showing cur_*, applying nxt_* mid-frame or in the wrap cycle.
  task automatic check_frame(input logic [15:0] cur_dig, input logic [3:0] cur_dp,
                             input logic [3:0] cur_blk, input logic [15:0] nxt_dig,
                             input logic [3:0] nxt_dp, input logic [3:0] nxt_blk,
                             input bit late);
    logic [3:0] exp_an;
    logic [7:0] exp_ca;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if ((late && d == 3 && c == 3) || (!late && d == 1 && c == 2)) begin
          digits = nxt_dig;
          dp     = nxt_dp;
          blank  = nxt_blk;
        end
        step();
        exp_an = cur_blk[d] ? 4'hF : ~(4'b0001 << d);
        exp_ca = cur_blk[d] ? 8'hFF : (seg_tab[cur_dig[4*d +: 4]] & (cur_dp[d] ? 8'h7F : 8'hFF));
        check_val($sformatf("an_%h_d%0d_c%0d", cur_dig, d, c), 32'(anode), 32'(exp_an));
        check_val($sformatf("ca_%h_d%0d_c%0d", cur_dig, d, c), 32'(cathode), 32'(exp_ca));
        check_val($sformatf("fd_%h_d%0d_c%0d", cur_dig, d, c), 32'(frame_done),
                  32'((d == 3 && c == 3) ? 1 : 0));
      end
    end
  endtask

  initial begin
    int cnt;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    reset      = 1'b1;
    digits     = 16'h3210;
    dp         = 4'h0;
    blank      = 4'h0;
    brightness = MAIN_BRIGHT;
`ifdef DISPLAY_MUX_PWM_EN
    p_reset      = 1'b1;
    p_brightness = 4'd3;
`endif

    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("rst%0d", i));
    end
    reset = 1'b0;
`ifdef DISPLAY_MUX_PWM_EN
    p_reset = 1'b0;
`endif
    step();
    check_idle("load_cycle");

    // Basic scan, then A..F on digit 0 (each change applied mid-frame).
    check_frame(16'h3210, 4'h0, 4'h0, 16'h321A, 4'h0, 4'h0, 1'b0);
    check_frame(16'h321A, 4'h0, 4'h0, 16'h321B, 4'h0, 4'h0, 1'b0);
    check_frame(16'h321B, 4'h0, 4'h0, 16'h321C, 4'h0, 4'h0, 1'b0);
    check_frame(16'h321C, 4'h0, 4'h0, 16'h321D, 4'h0, 4'h0, 1'b0);
    check_frame(16'h321D, 4'h0, 4'h0, 16'h321E, 4'h0, 4'h0, 1'b0);
    check_frame(16'h321E, 4'h0, 4'h0, 16'h321F, 4'h0, 4'h0, 1'b0);
    // Blank/dp values applied exactly in the wrap cycle must be captured.
    check_frame(16'h321F, 4'h0, 4'h0, 16'h8888, 4'h1, 4'h4, 1'b1);
    check_frame(16'h8888, 4'h1, 4'h4, 16'h3210, 4'h0, 4'h0, 1'b0);
    check_frame(16'h3210, 4'h0, 4'h0, 16'h3210, 4'h0, 4'h0, 1'b0);

    // Reset during digit 2's slot.
    for (int i = 0; i < 10; i++) step();
    check_val("pre_rst_anode", 32'(anode), 32'h0B);
    reset = 1'b1;
    step();
    check_idle("mid_rst");
    reset = 1'b0;
    step();
    check_idle("mid_rst_load");
    check_frame(16'h3210, 4'h0, 4'h0, 16'h3210, 4'h0, 4'h0, 1'b0);

`ifdef DISPLAY_MUX_PWM_EN
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (p_anode != 4'hF) cnt++;
    end
    check_val("pwm_duty_b3", 32'(cnt), 32'd8);
    p_brightness = 4'd15;
    for (int i = 0; i < 140; i++) step();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (p_anode != 4'hF) cnt++;
    end
    check_val("pwm_duty_b15", 32'(cnt), 32'd32);
`else
    cnt = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
